// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   Decode -> execute pipeline register of the 5-stage RV32I core.
//   Each rising edge it either loads a bubble (flush_e), holds (stall_e) or
//   captures the decode-stage control, operands, PCs and register indices.
//   Priority: flush_e > stall_e > capture. Latency one cycle; every output is
//   a flop, so there is no combinational path from any input to any output.
//
//   Handshake: there is no valid/ready pair here. valid_d marks a real decode
//   instruction, valid_e marks a real execute instruction; stall_e is the
//   back-pressure (hold) and flush_e the kill (bubble) from the hazard unit.
//
// Parameters
//   XLEN   datapath width of RD1/RD2/PC/PCPlus4/ImmExt
//   CNT_W  width of the performance counters
//
// Configuration macro
//   ID_EX_PERF_EN  when defined, bubble_cnt counts flush edges and stall_cnt
//                  counts held edges (stall without flush), both saturating.
//                  When undefined both outputs are tied to zero.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall_e, flush_e      hold / bubble requests for the execute slot
//   valid_d / valid_e     slot-valid in decode / execute
//   <name>D / <name>E     decode-side input / registered execute-side copy
//   bubble_cnt, stall_cnt performance counters (see macro above)
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             ALUSrcD,
  input  logic             JAL_JALR_SELD,
  input  logic             loadimm_selD,
  input  logic [1:0]       ResultSrcD,
  input  logic [4:0]       ALUControlD,
  input  logic [2:0]       funct3D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             ALUSrcE,
  output logic             JAL_JALR_SELE,
  output logic             loadimm_selE,
  output logic [1:0]       ResultSrcE,
  output logic [4:0]       ALUControlE,
  output logic [2:0]       funct3E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             valid_e,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // An invalid decode slot is captured with its control zeroed, so decoder
  // don't-care bits can never make a non-instruction write state.
  logic ctrl_kill;
  assign ctrl_kill = ~valid_d;

  // Control fields and slot-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteE     <= 1'b0;
      MemWriteE     <= 1'b0;
      BranchE       <= 1'b0;
      JumpE         <= 1'b0;
      ALUSrcE       <= 1'b0;
      JAL_JALR_SELE <= 1'b0;
      loadimm_selE  <= 1'b0;
      ResultSrcE    <= 2'b00;
      ALUControlE   <= 5'b00000;
      funct3E       <= 3'b000;
      valid_e       <= 1'b0;
    end else if (flush_e || (!stall_e && ctrl_kill)) begin
      // Bubble: architecturally inert execute slot.
      RegWriteE     <= 1'b0;
      MemWriteE     <= 1'b0;
      BranchE       <= 1'b0;
      JumpE         <= 1'b0;
      ALUSrcE       <= 1'b0;
      JAL_JALR_SELE <= 1'b0;
      loadimm_selE  <= 1'b0;
      ResultSrcE    <= 2'b00;
      ALUControlE   <= 5'b00000;
      funct3E       <= 3'b000;
      valid_e       <= 1'b0;
    end else if (!stall_e) begin
      RegWriteE     <= RegWriteD;
      MemWriteE     <= MemWriteD;
      BranchE       <= BranchD;
      JumpE         <= JumpD;
      ALUSrcE       <= ALUSrcD;
      JAL_JALR_SELE <= JAL_JALR_SELD;
      loadimm_selE  <= loadimm_selD;
      ResultSrcE    <= ResultSrcD;
      ALUControlE   <= ALUControlD;
      funct3E       <= funct3D;
      valid_e       <= 1'b1;
    end
  end

  // Data fields and register indices. A flush clears them; an invalid decode
  // slot still captures them (only its control is suppressed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      Rs1E     <= 5'd0;
      Rs2E     <= 5'd0;
      RdE      <= 5'd0;
    end else if (flush_e) begin
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      Rs1E     <= 5'd0;
      Rs2E     <= 5'd0;
      RdE      <= 5'd0;
    end else if (!stall_e) begin
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      ImmExtE  <= ImmExtD;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
    end
  end

`ifdef ID_EX_PERF_EN
  // Saturating counters: they stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (flush_e && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (stall_e && !flush_e && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One slot of the pipeline as seen by the architecture.
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        jal_jalr_sel;
    logic        loadimm_sel;
    logic [1:0]  result_src;
    logic [4:0]  alu_control;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } slot_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_e = 1'b0;
  logic flush_e = 1'b0;
  slot_t d = '0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic             JAL_JALR_SELE, loadimm_selE;
  logic [1:0]       ResultSrcE;
  logic [4:0]       ALUControlE;
  logic [2:0]       funct3E;
  logic [XLEN-1:0]  RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             valid_e;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(d.valid),
    .RegWriteD(d.reg_write), .MemWriteD(d.mem_write), .BranchD(d.branch),
    .JumpD(d.jump), .ALUSrcD(d.alu_src), .JAL_JALR_SELD(d.jal_jalr_sel),
    .loadimm_selD(d.loadimm_sel), .ResultSrcD(d.result_src),
    .ALUControlD(d.alu_control), .funct3D(d.funct3),
    .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .PCPlus4D(d.pc_plus4),
    .ImmExtD(d.imm_ext), .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .ALUSrcE(ALUSrcE), .JAL_JALR_SELE(JAL_JALR_SELE),
    .loadimm_selE(loadimm_selE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .valid_e(valid_e), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  slot_t act;
  assign act = {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, JAL_JALR_SELE,
                loadimm_selE, ResultSrcE, ALUControlE, funct3E,
                RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, valid_e};

  // ---------------- reference model ----------------
  slot_t      m_slot;
  int         m_bubble;
  int         m_stall;
  bit         perf_en;

  function automatic slot_t strip_ctrl(slot_t s);
    slot_t r;
    r = s;
    r.reg_write = 0; r.mem_write = 0; r.branch = 0; r.jump = 0;
    r.alu_src = 0; r.jal_jalr_sel = 0; r.loadimm_sel = 0;
    r.result_src = 0; r.alu_control = 0; r.funct3 = 0; r.valid = 0;
    return r;
  endfunction

  // Architectural behaviour of one clock edge.
  task automatic model_edge();
    if (flush_e) begin
      m_slot = '0;
      if (m_bubble < int'(CNT_MAX)) m_bubble++;
    end else if (stall_e) begin
      if (m_stall < int'(CNT_MAX)) m_stall++;
    end else begin
      m_slot = d.valid ? d : strip_ctrl(d);
    end
  endtask

  task automatic model_reset();
    m_slot = '0;
    m_bubble = 0;
    m_stall = 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".slot"}, 256'(act), 256'(m_slot));
    chk({tag, ".bubble_cnt"}, 256'(bubble_cnt), perf_en ? 256'(m_bubble) : 256'(0));
    chk({tag, ".stall_cnt"}, 256'(stall_cnt), perf_en ? 256'(m_stall) : 256'(0));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic rand_d();
    d.reg_write    = 1'($urandom);
    d.mem_write    = 1'($urandom);
    d.branch       = 1'($urandom);
    d.jump         = 1'($urandom);
    d.alu_src      = 1'($urandom);
    d.jal_jalr_sel = 1'($urandom);
    d.loadimm_sel  = 1'($urandom);
    d.result_src   = 2'($urandom);
    d.alu_control  = 5'($urandom);
    d.funct3       = 3'($urandom);
    d.rd1          = $urandom;
    d.rd2          = $urandom;
    d.pc           = $urandom;
    d.pc_plus4     = d.pc + 32'd4;
    d.imm_ext      = $urandom;
    d.rs1          = 5'($urandom);
    d.rs2          = 5'($urandom);
    d.rd           = 5'($urandom);
    d.valid        = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset.slot", 256'(act), 256'(0));
    chk("reset.counters", 256'({bubble_cnt, stall_cnt}), 256'(0));
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  slot_t snap;
  int    stall_before;
  int    bubble_before;

  initial begin
`ifdef ID_EX_PERF_EN
    perf_en = 1'b1;
`else
    perf_en = 1'b0;
`endif
    model_reset();
    #2;
    chk("por.slot", 256'(act), 256'(0));
    @(posedge clk);
    do_reset();

    // Capture of a real instruction.
    rand_d();
    d.valid = 1'b1; d.alu_control = 5'b00001; d.rd = 5'd5; d.rd1 = 32'h1234;
    step("capture");
    chk("capture.alu_control", 256'(ALUControlE), 256'(5'b00001));
    chk("capture.rd", 256'(RdE), 256'(5));
    chk("capture.rd1", 256'(RD1E), 256'(32'h1234));
    chk("capture.valid_e", 256'(valid_e), 256'(1));

    // Stall three edges with changing inputs.
    snap = act;
    stall_before = m_stall;
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step("stall");
      chk("stall.hold", 256'(act), 256'(snap));
    end
    chk("stall.count3", 256'(stall_cnt), perf_en ? 256'(stall_before + 3) : 256'(0));

    // Flush together with stall: bubble wins.
    stall_before  = m_stall;
    bubble_before = m_bubble;
    rand_d();
    d.valid = 1'b1; d.mem_write = 1'b1; d.reg_write = 1'b1; d.rd = 5'd9;
    flush_e = 1'b1;
    step("flush_stall");
    chk("flush_stall.inert",
        256'({MemWriteE, RegWriteE, BranchE, JumpE, valid_e, RdE}), 256'(0));
    chk("flush_stall.bubble_cnt", 256'(bubble_cnt),
        perf_en ? 256'(bubble_before + 1) : 256'(0));
    chk("flush_stall.stall_cnt", 256'(stall_cnt),
        perf_en ? 256'(stall_before) : 256'(0));
    flush_e = 1'b0;
    stall_e = 1'b0;

    // Invalid decode slot: control suppressed, data captured.
    rand_d();
    d.valid = 1'b0; d.reg_write = 1'b1; d.jump = 1'b1; d.rd1 = 32'hCAFE_0001;
    step("invalid_d");
    chk("invalid_d.ctrl", 256'({RegWriteE, JumpE, valid_e}), 256'(0));
    chk("invalid_d.rd1", 256'(RD1E), 256'(32'hCAFE_0001));

    // Asynchronous reset between edges.
    rand_d();
    d.valid = 1'b1; d.reg_write = 1'b1;
    step("pre_reset");
    chk("pre_reset.reg_write", 256'(RegWriteE), 256'(1));
    do_reset();

    // Counter saturation: 17 flush edges.
    flush_e = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_d();
      step("sat");
    end
    chk("sat.bubble_cnt", 256'(bubble_cnt), perf_en ? 256'(CNT_MAX) : 256'(0));
    flush_e = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      rand_d();
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
